// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - read/accumulate/write sequencer for one fully-connected MLP layer
// Optional macro LAYER_BIAS_EN prepends a bias term (neuron address 0) to every output neuron.
module layer_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int WADDR_W = 16,
  parameter int CNT_W   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  in_base,
  input  logic [ADDR_W-1:0]  out_base,
  input  logic [WADDR_W-1:0] w_base,
  input  logic [CNT_W-1:0]   n_in,
  input  logic [CNT_W-1:0]   n_out,
  output logic [ADDR_W-1:0]  input_addr,
  output logic               rd_issue,
  output logic [WADDR_W-1:0] weight_addr,
  output logic               acc_clear,
  output logic               acc_en,
  output logic               write_enable,
  output logic [ADDR_W-1:0]  output_addr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

`ifdef LAYER_BIAS_EN
  localparam logic [CNT_W:0] BIAS_TERMS = (CNT_W+1)'(1);
  localparam logic           BIAS_ON    = 1'b1;
`else
  localparam logic [CNT_W:0] BIAS_TERMS = (CNT_W+1)'(0);
  localparam logic           BIAS_ON    = 1'b0;
`endif

  localparam logic [CNT_W:0]   ONE_T = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_N = CNT_W'(1);
  localparam logic [ADDR_W-1:0]  ONE_A = ADDR_W'(1);
  localparam logic [WADDR_W-1:0] ONE_W = WADDR_W'(1);

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  in_base_r;
  logic [ADDR_W-1:0]  in_ptr;
  logic [ADDR_W-1:0]  out_ptr;
  logic [WADDR_W-1:0] w_ptr;
  logic [CNT_W:0]     n_terms;
  logic [CNT_W:0]     term_cnt;
  logic [CNT_W-1:0]   n_out_r;
  logic [CNT_W-1:0]   out_cnt;
  logic               acc_en_r;
  logic               acc_clear_r;

  logic zero_cfg;
  logic last_term;
  logic last_neuron;
  logic bias_term;

  assign zero_cfg    = (n_in == '0) || (n_out == '0);
  assign last_term   = (term_cnt == (n_terms - ONE_T));
  assign last_neuron = (out_cnt == (n_out_r - ONE_N));
  assign bias_term   = BIAS_ON && (term_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_issue     = 1'b0;
    input_addr   = '0;
    weight_addr  = '0;
    write_enable = 1'b0;
    output_addr  = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = zero_cfg ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rd_issue    = 1'b1;
        busy        = 1'b1;
        input_addr  = bias_term ? '0 : in_ptr;
        weight_addr = w_ptr;
        if (last_term) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy         = 1'b1;
        write_enable = 1'b1;
        output_addr  = out_ptr;
        state_nxt    = last_neuron ? S_DONE : S_READ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Config is captured once at start; pointers then walk without looking at the live inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_base_r <= '0;
      in_ptr    <= '0;
      out_ptr   <= '0;
      w_ptr     <= '0;
      n_terms   <= '0;
      term_cnt  <= '0;
      n_out_r   <= '0;
      out_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            in_base_r <= in_base;
            in_ptr    <= in_base;
            out_ptr   <= out_base;
            w_ptr     <= w_base;
            n_terms   <= {1'b0, n_in} + BIAS_TERMS;
            n_out_r   <= n_out;
            term_cnt  <= '0;
            out_cnt   <= '0;
          end
        end
        S_READ: begin
          term_cnt <= term_cnt + ONE_T;
          w_ptr    <= w_ptr + ONE_W;
          if (!bias_term) begin
            in_ptr <= in_ptr + ONE_A;
          end
        end
        S_WRITE: begin
          term_cnt <= '0;
          in_ptr   <= in_base_r;
          out_ptr  <= out_ptr + ONE_A;
          out_cnt  <= out_cnt + ONE_N;
        end
        default: begin
        end
      endcase
    end
  end

  // MAC strobes trail the read by one cycle to line up with the registered memory data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_en_r    <= 1'b0;
      acc_clear_r <= 1'b0;
    end else begin
      acc_en_r    <= rd_issue;
      acc_clear_r <= rd_issue && (term_cnt == '0);
    end
  end

  assign acc_en    = acc_en_r;
  assign acc_clear = acc_clear_r;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - self-checking bench for layer_sequencer against a cycle-timing model
module tb_layer_sequencer;

  localparam int ADDR_W  = 12;
  localparam int WADDR_W = 16;
  localparam int CNT_W   = 12;
`ifdef LAYER_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  in_base = '0;
  logic [ADDR_W-1:0]  out_base = '0;
  logic [WADDR_W-1:0] w_base = '0;
  logic [CNT_W-1:0]   n_in = '0;
  logic [CNT_W-1:0]   n_out = '0;
  logic [ADDR_W-1:0]  input_addr;
  logic               rd_issue;
  logic [WADDR_W-1:0] weight_addr;
  logic               acc_clear;
  logic               acc_en;
  logic               write_enable;
  logic [ADDR_W-1:0]  output_addr;
  logic               busy;
  logic               done;

  layer_sequencer #(.ADDR_W(ADDR_W), .WADDR_W(WADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_base(in_base), .out_base(out_base), .w_base(w_base),
    .n_in(n_in), .n_out(n_out),
    .input_addr(input_addr), .rd_issue(rd_issue), .weight_addr(weight_addr),
    .acc_clear(acc_clear), .acc_en(acc_en), .write_enable(write_enable),
    .output_addr(output_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int in_base;
    int out_base;
    int w_base;
    int n_in;
    int n_out;
    int done_cyc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Expected output bundle in cycle c after the start edge, from the per-neuron timing rules.
  function automatic logic [45:0] model(vec_t v, int c);
    int t, per, total, j, p, k;
    logic rd, ce, ae, we, bz, dn;
    logic [11:0] ia, oa;
    logic [15:0] wa;
    rd = 0; ce = 0; ae = 0; we = 0; bz = 0; dn = 0;
    ia = '0; oa = '0; wa = '0;
    t = v.n_in + B;
    per = t + 2;
    total = (v.n_in == 0 || v.n_out == 0) ? 0 : v.n_out * per;
    if (c >= 1 && c <= total) begin
      bz = 1;
      j = (c - 1) / per;
      p = (c - 1) % per + 1;
      if (p <= t) begin
        rd = 1;
        k = p - 1;
        ia = (B == 1 && k == 0) ? 12'd0 : 12'(v.in_base + k - B);
        wa = 16'(v.w_base + j * t + k);
      end
      ae = (p >= 2 && p <= t + 1);
      ce = (p == 2);
      if (p == per) begin
        we = 1;
        oa = 12'(v.out_base + j);
      end
    end
    dn = (c == total + 1);
    return {rd, ia, wa, ce, ae, we, oa, bz, dn};
  endfunction

  function automatic int expected_done(vec_t v);
    if (v.n_in == 0 || v.n_out == 0) return 1;
    return v.n_out * (v.n_in + B + 2) + 1;
  endfunction

  task automatic check(string name, logic [45:0] exp);
    logic [45:0] act;
    act = {rd_issue, input_addr, weight_addr, acc_clear, acc_en, write_enable, output_addr, busy, done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_start(vec_t v);
    @(negedge clk);
    in_base  = 12'(v.in_base);
    out_base = 12'(v.out_base);
    w_base   = 16'(v.w_base);
    n_in     = 12'(v.n_in);
    n_out    = 12'(v.n_out);
    start    = 1'b1;
    @(posedge clk);
  endtask

  task automatic run_layer(string tag, vec_t v);
    int seen_done;
    seen_done = -1;
    drive_start(v);
    for (int c = 1; c <= v.done_cyc + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_base = ~in_base;
      n_in = n_in + 12'd1;
      check($sformatf("%s_c%0d", tag, c), model(v, c));
      if (done && seen_done < 0) seen_done = c;
    end
    checks++;
    if (seen_done != v.done_cyc) begin
      errors++;
      $display("FAIL %s_done_cycle actual=%0d required=%0d", tag, seen_done, v.done_cyc);
    end
  endtask

  vec_t tbl[5];
  vec_t rv;
  vec_t basic;

  initial begin
    tbl[0] = '{in_base: 1,    out_base: 100,  w_base: 0,     n_in: 3, n_out: 2, done_cyc: (B == 1) ? 13 : 11};
    tbl[1] = '{in_base: 7,    out_base: 9,    w_base: 5,     n_in: 0, n_out: 5, done_cyc: 1};
    tbl[2] = '{in_base: 7,    out_base: 9,    w_base: 5,     n_in: 3, n_out: 0, done_cyc: 1};
    tbl[3] = '{in_base: 4094, out_base: 4095, w_base: 65534, n_in: 4, n_out: 2, done_cyc: 2 * (6 + B) + 1};
    tbl[4] = '{in_base: 0,    out_base: 0,    w_base: 0,     n_in: 1, n_out: 1, done_cyc: 4 + B};
    basic = tbl[0];

    #1 reset = 1'b1;
    #1 check("reset_async", 46'd0);
    @(negedge clk);
    check("reset_hold", 46'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 46'd0);

    for (int i = 0; i < 5; i++) run_layer($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 8; i++) begin
      rv.in_base  = (i % 2 == 0) ? $urandom_range(4090, 4095) : $urandom_range(0, 4095);
      rv.out_base = $urandom_range(0, 4095);
      rv.w_base   = (i % 3 == 0) ? $urandom_range(65530, 65535) : $urandom_range(0, 65535);
      rv.n_in     = $urandom_range(0, 5);
      rv.n_out    = $urandom_range(0, 3);
      rv.done_cyc = expected_done(rv);
      run_layer($sformatf("rnd%0d", i), rv);
    end

    // Second start in cycle 3 is ignored; reset in cycle 4 abandons the layer.
    drive_start(basic);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("busy_start_c%0d", c), model(basic, c));
      start = (c == 3);
    end
    #1 reset = 1'b1;
    #1 check("reset_mid_layer", 46'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle%0d", c), 46'd0);
    end
    run_layer("after_reset", basic);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequencer for one fully-connected MLP layer. It drives the read address, write address and write enable of the 4096 x 16-bit neuron memory, and the address of the weight memory. It also generates clear/enable strobes for the external multiply-accumulate unit, whose registered result feeds the neuron memory data port. One `start` computes every output neuron of the layer, then pulses `done`.

## Interface
Parameters:
- `ADDR_W`, 12: neuron address width (matches the neuron memory).
- `WADDR_W`, 16: weight address width.
- `CNT_W`, 12: width of the neuron-count inputs.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin a layer; sampled only in IDLE.
- `in_base`  in  ADDR_W  neuron address of input neuron 0.
- `out_base`  in  ADDR_W  neuron address for output neuron 0.
- `w_base`  in  WADDR_W  weight address of the first weight.
- `n_in`  in  CNT_W  number of input neurons.
- `n_out`  in  CNT_W  number of output neurons.
- `input_addr`  out  ADDR_W  neuron memory read address.
- `rd_issue`  out  1  `input_addr`/`weight_addr` are a valid read this cycle.
- `weight_addr`  out  WADDR_W  weight memory read address.
- `acc_clear`  out  1  MAC loads the product instead of adding it (first term).
- `acc_en`  out  1  MAC consumes the neuron/weight data this cycle.
- `write_enable`  out  1  neuron memory write strobe.
- `output_addr`  out  ADDR_W  neuron memory write address.
- `busy`  out  1  layer in progress.
- `done`  out  1  one-cycle pulse at layer completion.

## Operation
- `start` high in IDLE latches all config inputs. Config changes afterwards are ignored until the next start.
- If `n_in`==0 or `n_out`==0 at start: no reads or writes occur, and `done` pulses in the next cycle.
- States and transitions:
  - IDLE -> READ on `start`.
  - READ issues one term per cycle. After the last term -> DRAIN.
  - DRAIN (1 cycle) -> WRITE.
  - WRITE (1 cycle) -> READ if output neurons remain, else -> DONE.
  - DONE (1 cycle, `done`=1, `busy`=0) -> IDLE.
- READ term k of output neuron j:
  - `input_addr` = in_base+k, modulo 2^ADDR_W.
  - `weight_addr` = the weight pointer, which is then incremented.
- The weight pointer starts at `w_base` and runs continuously across output neurons (row-major), wrapping modulo 2^WADDR_W.
- `acc_en` is `rd_issue` delayed by 1 cycle, matching the memories' 1-cycle registered read. `acc_clear` accompanies the first `acc_en` of each output neuron.
- In WRITE: `write_enable`=1 and `output_addr`=out_base+j (modulo 2^ADDR_W). The MAC result is valid on the data port in this cycle.
- `start` is ignored while `busy`.
- Overlapping input and output regions are not checked. Writes go to the memory as issued.
- `reset` asserted at any time:
  - Immediately zeroes every output and all counters.
  - Returns the state to IDLE.
  - A partially computed layer is abandoned; writes already done remain in memory.

## Timing
- Reset values: all outputs 0; state IDLE.
- `start` is sampled at edge E0. Cycle c means the cycle after edge E0+c-1.
- Let T be the number of terms per neuron (T = n_in, or n_in+1 with bias).
- For output neuron j (base cycle b = j*(T+2)):
  - `rd_issue` in cycles b+1 .. b+T.
  - `acc_en` in cycles b+2 .. b+T+1; `acc_clear` in cycle b+2.
  - `write_enable` in cycle b+T+2.
- `done` is high in cycle n_out*(T+2)+1.
- `busy` is high in cycles 1 .. n_out*(T+2), and low when `done` is high.
- `write_enable` and `rd_issue` are never high in the same cycle.

## Configuration
- Macro `LAYER_BIAS_EN`.
- When defined, each output neuron gets one extra leading term:
  - `input_addr`=0, the neuron memory's constant-1 bias cell.
  - It consumes one weight, so T = n_in+1.
  - This term carries `acc_clear`; input neuron k then follows at term k+1.
- When undefined: T = n_in, and address 0 is never read unless `in_base`+k reaches it.

## Test plan
- Basic layer, bias off: n_in=3, n_out=2, in_base=1, out_base=100, w_base=0.
  - Reads (1,0),(2,1),(3,2) in cycles 1-3, then (1,3),(2,4),(3,5) in cycles 6-8.
  - Writes to 100 in cycle 5 and to 101 in cycle 10; `done` in cycle 11.
- Bias on, same config:
  - Per neuron, `input_addr` sequence 0,1,2,3 with weights 0-3, then 4-7.
  - Writes in cycles 6 and 12; `done` in cycle 13.
- Zero size: n_in=0, n_out=5.
  - No `rd_issue` and no `write_enable`; `done` in cycle 1.
- Address wrap: in_base=4094, n_in=4.
  - `input_addr` sequence 4094, 4095, 0, 1.
  - w_base=65534 gives `weight_addr` sequence 65534, 65535, 0, 1.
- Start while busy, then reset mid-layer:
  - A second `start` in cycle 3 has no effect.
  - `reset` in cycle 4 forces all outputs to 0 in the same cycle, and no `done` pulse follows.
  - A new `start` after reset behaves as in the basic-layer case.
